// File: rtl/program_loader.sv
// program_loader: boot-time loader from the UART_1 RX FIFO into program memory.
// Frame: SYNC_BYTE, LEN (instructions), LEN*4 data bytes (little-endian per
// instruction), then an optional CSUM byte.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to compile in the CSUM
// state and the checksum accumulator.
//
// Handshakes:
//   rx: a byte is taken in the cycle rx_flag=1 is registered (rx_data sampled
//       there); rx_use strobes high for exactly the following cycle, and
//       rx_flag is ignored during that strobe cycle so the FIFO can advance.
//   pm: pm_wr_ins is asserted only while pm_wr_idle=1; pm_addr_wr/pm_data_wr
//       are valid from that cycle and held until pm_wr_idle returns high.
module program_loader #(
    parameter int         PROGRAM_MEMORY_SIZE = 64,
    parameter int         PM_ADDR_WIDTH       = $clog2(PROGRAM_MEMORY_SIZE) + 2,
    parameter logic [7:0] SYNC_BYTE           = 8'hA5,
    parameter int         TIMEOUT_CYCLES      = 1_000_000,
    parameter int         TIMEOUT_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_flag,
    output logic                     rx_use,
    output logic [7:0]               pm_data_wr,
    output logic [PM_ADDR_WIDTH-1:0] pm_addr_wr,
    output logic                     pm_wr_ins,
    input  logic                     pm_wr_idle,
    output logic                     load_busy,
    output logic                     load_done,
    output logic                     load_error,
    output logic [7:0]               instr_count,
    output logic [2:0]               dbg_state
);

    // Remaining-byte counter must hold LEN*4 up to 4*PROGRAM_MEMORY_SIZE.
    localparam int CNT_WIDTH = PM_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LEN      = 3'd1,
        S_DATA_POP = 3'd2,
        S_DATA_WR  = 3'd3,
        S_WR_WAIT  = 3'd4,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM     = 3'd5,
`endif
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   can_pop;
    logic                   do_pop;
    logic                   wait_state;
    logic                   timeout_hit;
    logic                   len_bad;
    logic                   wr_skip;
    logic [CNT_WIDTH-1:0]   byte_cnt;
    logic [7:0]             len_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_acc;
`endif

    // The cycle after a pop belongs to the FIFO, so never sample during rx_use.
    assign can_pop   = rx_flag && !rx_use;
    assign len_bad   = (rx_data == 8'd0) || ({24'd0, rx_data} > 32'(PROGRAM_MEMORY_SIZE));
    assign pm_wr_ins = (state == S_DATA_WR) && pm_wr_idle;
    assign load_done = (state == S_DONE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state, pop decision and inter-byte timeout detection.
    always_comb begin
        next_state = state;
        do_pop     = 1'b0;
        wait_state = (state == S_LEN) || (state == S_DATA_POP);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        wait_state = wait_state || (state == S_CSUM);
`endif
        timeout_hit = wait_state && !rx_flag &&
                      (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
        case (state)
            S_IDLE: begin
                if (can_pop) begin
                    do_pop = 1'b1;
                    if (rx_data == SYNC_BYTE) next_state = S_LEN;
                end
            end
            S_LEN: begin
                if (can_pop) begin
                    do_pop     = 1'b1;
                    next_state = len_bad ? S_ERR : S_DATA_POP;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end
            S_DATA_POP: begin
                if (can_pop) begin
                    do_pop     = 1'b1;
                    next_state = S_DATA_WR;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end
            S_DATA_WR: begin
                if (pm_wr_idle) next_state = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!wr_skip && pm_wr_idle) begin
                    if (byte_cnt == CNT_WIDTH'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        next_state = S_CSUM;
`else
                        next_state = S_DONE;
`endif
                    end else begin
                        next_state = S_DATA_POP;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (can_pop) begin
                    do_pop     = 1'b1;
                    next_state = (rx_data == csum_acc) ? S_DONE : S_ERR;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end
`endif
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: pop strobe, timeout counter, address/data, counters and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_use      <= 1'b0;
            pm_data_wr  <= 8'd0;
            pm_addr_wr  <= '0;
            load_busy   <= 1'b0;
            load_error  <= 1'b0;
            instr_count <= 8'd0;
            byte_cnt    <= '0;
            len_q       <= 8'd0;
            tmo_cnt     <= '0;
            wr_skip     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_acc    <= 8'd0;
`endif
        end else begin
            rx_use  <= do_pop;
            // The single skip cycle lets the memory drop pm_wr_idle first.
            wr_skip <= (state == S_DATA_WR) && (next_state == S_WR_WAIT);
            if (!wait_state || do_pop) tmo_cnt <= '0;
            else if (!rx_flag)         tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
            case (state)
                S_IDLE: begin
                    if (do_pop && rx_data == SYNC_BYTE) begin
                        load_busy  <= 1'b1;
                        load_error <= 1'b0;
                        pm_addr_wr <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_acc   <= 8'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (do_pop && !len_bad) begin
                        len_q    <= rx_data;
                        byte_cnt <= CNT_WIDTH'({rx_data, 2'b00});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_acc <= rx_data;
`endif
                    end
                end
                S_DATA_POP: begin
                    if (do_pop) begin
                        pm_data_wr <= rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_acc   <= csum_acc + rx_data;
`endif
                    end
                end
                S_WR_WAIT: begin
                    if (!wr_skip && pm_wr_idle) begin
                        pm_addr_wr <= pm_addr_wr + PM_ADDR_WIDTH'(1);
                        byte_cnt   <= byte_cnt - CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
            if (next_state == S_ERR && state != S_ERR) begin
                load_busy  <= 1'b0;
                load_error <= 1'b1;
            end
            if (next_state == S_DONE && state != S_DONE) begin
                load_busy   <= 1'b0;
                instr_count <= len_q;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: FIFO and program-memory models, frame vector
// table, timeout, memory back-pressure and mid-frame reset sequences.
module tb_program_loader;

    localparam int AW  = 8;
    localparam int TMO = 16;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_flag = 1'b0;
    logic          rx_use;
    logic [7:0]    pm_data_wr;
    logic [AW-1:0] pm_addr_wr;
    logic          pm_wr_ins;
    logic          pm_wr_idle = 1'b1;
    logic          load_busy;
    logic          load_done;
    logic          load_error;
    logic [7:0]    instr_count;
    logic [2:0]    dbg_state;

    // Clock.
    always #5 clk = ~clk;

    program_loader #(
        .PROGRAM_MEMORY_SIZE(64),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_flag(rx_flag), .rx_use(rx_use),
        .pm_data_wr(pm_data_wr), .pm_addr_wr(pm_addr_wr),
        .pm_wr_ins(pm_wr_ins), .pm_wr_idle(pm_wr_idle),
        .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
        .instr_count(instr_count), .dbg_state(dbg_state)
    );

    typedef struct {
        string        name;
        logic [127:0] seq;   // frame bytes, right-aligned, first byte most significant
        int           n;
        int           off;   // index of first data byte
        int           nwr;
        int           done;
        bit           err;
        int           cnt;
    } vec_t;

    logic [7:0]    fifo_q[$];
    logic [15:0]   exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            wr_cnt   = 0;
    int            done_cnt = 0;
    int            mem_lat  = 0;
    int            mem_busy = 0;
    bit            drop_next = 1'b0;
    logic [AW-1:0] lat_addr = '0;
    logic [7:0]    lat_data = 8'h00;
    vec_t          vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h at %0t", nm, act, $time);
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] s, input int n, input int k);
        return s[8*(n-1-k) +: 8];
    endfunction

    // Monitors, program-memory model with scoreboard, and RX FIFO model.
    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (mem_busy > 0) begin
            check("wr_while_busy", {31'd0, pm_wr_ins}, 32'd0);
            check("addr_hold", {24'd0, pm_addr_wr}, {24'd0, lat_addr});
            check("data_hold", {24'd0, pm_data_wr}, {24'd0, lat_data});
            if (drop_next) begin
                pm_wr_idle = 1'b0;
                drop_next  = 1'b0;
            end else begin
                mem_busy--;
                if (mem_busy == 0) pm_wr_idle = 1'b1;
            end
        end else if (pm_wr_ins) begin
            wr_cnt++;
            lat_addr = pm_addr_wr;
            lat_data = pm_data_wr;
            if (exp_q.size() == 0) fail_now("unexpected_write", {16'd0, pm_addr_wr, pm_data_wr});
            else check("write", {16'd0, pm_addr_wr, pm_data_wr}, {16'd0, exp_q.pop_front()});
            if (mem_lat > 0) begin
                mem_busy  = mem_lat;
                drop_next = 1'b1;
            end
        end
        if (rx_use && fifo_q.size() > 0) fifo_q.delete(0);
        rx_flag = (fifo_q.size() > 0);
        rx_data = rx_flag ? fifo_q[0] : 8'h00;
    end

    task automatic wait_idle(input string nm);
        int quiet = 0;
        bit ok    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && dbg_state == 3'd0 && !rx_use && pm_wr_idle) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now({nm, "_idle_timeout"}, {29'd0, dbg_state});
    endtask

    // gap < 0: push the whole frame at once; otherwise hold rx_flag low for
    // exactly 'gap' cycles after every pop before the next byte arrives.
    task automatic run_seq(input string nm, input logic [127:0] seq, input int n,
                           input int off, input int nwr, input int exp_done,
                           input bit exp_err, input int exp_cnt, input int gap);
        int d0 = done_cnt;
        int w0 = wr_cnt;
        bit seen;
        for (int k = 0; k < nwr; k++) exp_q.push_back({AW'(k), byte_of(seq, n, off + k)});
        @(posedge clk); #1;
        if (gap < 0) begin
            for (int k = 0; k < n; k++) fifo_q.push_back(byte_of(seq, n, k));
        end else begin
            fifo_q.push_back(byte_of(seq, n, 0));
            for (int k = 1; k < n; k++) begin
                seen = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (rx_use) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) fail_now({nm, "_pop_timeout"}, k);
                repeat (gap) @(posedge clk);
                #1;
                fifo_q.push_back(byte_of(seq, n, k));
            end
        end
        wait_idle(nm);
        check({nm, "_done_pulses"}, done_cnt - d0, exp_done);
        check({nm, "_writes"}, wr_cnt - w0, nwr);
        check({nm, "_error"}, {31'd0, load_error}, {31'd0, exp_err});
        check({nm, "_instr_count"}, {24'd0, instr_count}, exp_cnt);
        check({nm, "_busy"}, {31'd0, load_busy}, 32'd0);
        check({nm, "_exp_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int  pops;
        bit  found;
        int  w0;

        vecs[0] = '{"basic",      128'hA5_01_13_00_00_00_14,                      7, 2, 4, 1, 1'b0, 1};
        vecs[1] = '{"junk_2instr",128'h00_FF_A5_02_11_22_33_44_A5_66_77_88_B6,    13, 4, 8, 1, 1'b0, 2};
        vecs[2] = '{"len_zero",   128'hA5_00,                                     2, 0, 0, 0, 1'b1, 2};
        vecs[3] = '{"len_over",   128'hA5_41,                                     2, 0, 0, 0, 1'b1, 2};
        vecs[4] = '{"clear_err",  128'hA5_01_AA_BB_CC_DD_0F,                      7, 2, 4, 1, 1'b0, 1};
        vecs[5] = '{"bad_csum",   128'hA5_01_01_02_03_04_0C,                      7, 2, 4,
                    CS ? 0 : 1, CS, 1};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_use", {31'd0, rx_use}, 0);
        check("rst_pm_wr_ins", {31'd0, pm_wr_ins}, 0);
        check("rst_pm_addr", {24'd0, pm_addr_wr}, 0);
        check("rst_pm_data", {24'd0, pm_data_wr}, 0);
        check("rst_busy", {31'd0, load_busy}, 0);
        check("rst_done", {31'd0, load_done}, 0);
        check("rst_error", {31'd0, load_error}, 0);
        check("rst_instr_count", {24'd0, instr_count}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Frame vector table.
        for (int r = 0; r < 6; r++)
            run_seq(vecs[r].name, vecs[r].seq, vecs[r].n, vecs[r].off, vecs[r].nwr,
                    vecs[r].done, vecs[r].err, vecs[r].cnt, -1);

        // Timeout: LEN arrives, then rx_flag stays low.
        w0 = wr_cnt;
        @(posedge clk); #1;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h01);
        pops  = 0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_use) pops++;
            if (pops == 2) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("tmo_pop_timeout", pops);
        else begin
            repeat (TMO - 1) @(negedge clk);
            check("tmo_before_state", {29'd0, dbg_state}, 2);
            check("tmo_before_busy", {31'd0, load_busy}, 1);
            check("tmo_before_error", {31'd0, load_error}, 0);
            @(negedge clk);
            check("tmo_at_state", {29'd0, dbg_state}, 7);
            check("tmo_at_error", {31'd0, load_error}, 1);
            check("tmo_at_busy", {31'd0, load_busy}, 0);
        end
        wait_idle("tmo");
        check("tmo_writes", wr_cnt - w0, 0);
        check("tmo_instr_count", {24'd0, instr_count}, 1);

        // Stall of TIMEOUT_CYCLES-1 between bytes still loads.
        run_seq("stall15", 128'hA5_01_5A_6B_7C_0D_4F, 7, 2, 4, 1, 1'b0, 1, TMO - 1);

        // Memory busy for 10 cycles after every write.
        mem_lat = 10;
        run_seq("mem_wait", 128'hA5_01_C1_C2_C3_C4_0B, 7, 2, 4, 1, 1'b0, 1, -1);
        mem_lat = 0;

        // Reset in the middle of a 2-instruction frame after two writes.
        exp_q.push_back({8'd0, 8'h01});
        exp_q.push_back({8'd1, 8'h02});
        w0 = wr_cnt;
        @(posedge clk); #1;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h03);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_cnt == w0 + 2) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("midrst_write_timeout", wr_cnt - w0);
        @(posedge clk); #1;
        rst = 1'b1;
        fifo_q.delete();
        @(posedge clk); #1;
        check("midrst_rx_use", {31'd0, rx_use}, 0);
        check("midrst_pm_wr_ins", {31'd0, pm_wr_ins}, 0);
        check("midrst_pm_addr", {24'd0, pm_addr_wr}, 0);
        check("midrst_pm_data", {24'd0, pm_data_wr}, 0);
        check("midrst_busy", {31'd0, load_busy}, 0);
        check("midrst_done", {31'd0, load_done}, 0);
        check("midrst_error", {31'd0, load_error}, 0);
        check("midrst_instr_count", {24'd0, instr_count}, 0);
        check("midrst_state", {29'd0, dbg_state}, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check("midrst_writes", wr_cnt - w0, 2);
        check("midrst_exp_left", exp_q.size(), 0);
        exp_q.delete();

        // Fresh frame after the reset.
        run_seq("after_rst", vecs[0].seq, vecs[0].n, vecs[0].off, vecs[0].nwr,
                vecs[0].done, vecs[0].err, vecs[0].cnt, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
